// File: rtl/split_bus_arbiter.sv
// rtl/split_bus_arbiter.sv - two-master / three-slave bus arbiter with split-transaction parking
module split_bus_arbiter #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic [SLAVE_LEN-1:0]  m1_slave_sel,
  input  logic [SLAVE_LEN-1:0]  m2_slave_sel,
  input  logic                  tx_done,
  input  logic [NUM_SLAVES-1:0] split_en,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  arb_busy,
  output logic                  bus_busy,
  output logic                  sel_master,
  output logic [SLAVE_LEN-1:0]  sel_slave,
  output logic [1:0]            split_hold,
  output logic                  sel_err,
  output logic                  timeout_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARB     = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]            state;
  logic [NUM_SLAVES-1:0] split_q;
  logic [NUM_SLAVES-1:0] split_valid;
  logic [NUM_SLAVES-1:0] split_owner;
  logic [NUM_SLAVES-1:0] resume;

  logic                  win_master;
  logic                  win_resume;
  logic [SLAVE_LEN-1:0]  win_slave;
  logic                  win_bad;

  logic [NUM_SLAVES-1:0] split_rise;
  logic [NUM_SLAVES-1:0] resume_set;
  logic [NUM_SLAVES-1:0] sel_mask;
  logic [NUM_SLAVES-1:0] win_mask;
  logic [NUM_SLAVES-1:0] m1_mask;
  logic [NUM_SLAVES-1:0] m2_mask;
  logic                  m1_elig;
  logic                  m2_elig;
  logic                  do_grant;
  logic                  res_clear;
  logic                  do_park;
  logic                  to_fire;

  logic                  pick_valid;
  logic                  pick_master;
  logic                  pick_resume;
  logic [SLAVE_LEN-1:0]  pick_slave;

  assign split_rise = split_en & ~split_q;
  assign resume_set = ~split_en & split_q & split_valid & ~resume;
  assign sel_mask   = NUM_SLAVES'(1) << sel_slave;
  assign win_mask   = NUM_SLAVES'(1) << win_slave;
  assign m1_mask    = NUM_SLAVES'(1) << m1_slave_sel;
  assign m2_mask    = NUM_SLAVES'(1) << m2_slave_sel;
  assign m1_elig    = m1_req && !split_hold[0] && !(|(split_valid & m1_mask));
  assign m2_elig    = m2_req && !split_hold[1] && !(|(split_valid & m2_mask));
  assign win_bad    = int'(win_slave) >= NUM_SLAVES;
  assign do_grant   = (state == ST_ARB) && !win_bad;
  assign res_clear  = do_grant && win_resume;
  assign do_park    = (state == ST_GRANT) && !tx_done && (|(split_rise & sel_mask));

  always_comb begin
    pick_valid  = 1'b0;
    pick_master = 1'b0;
    pick_resume = 1'b0;
    pick_slave  = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (resume[k]) begin
        pick_valid  = 1'b1;
        pick_resume = 1'b1;
        pick_master = split_owner[k];
        pick_slave  = SLAVE_LEN'(k);
      end
    end
    if (!pick_valid) begin
      if (m1_elig) begin
        pick_valid = 1'b1;
        pick_slave = m1_slave_sel;
      end else if (m2_elig) begin
        pick_valid  = 1'b1;
        pick_master = 1'b1;
        pick_slave  = m2_slave_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_q     <= '0;
      split_valid <= '0;
      split_owner <= '0;
      resume      <= '0;
      split_hold  <= 2'b00;
    end else begin
      split_q <= split_en;
      resume  <= (resume & ~(res_clear ? win_mask : '0)) | resume_set;
      if (res_clear) begin
        split_valid            <= split_valid & ~win_mask;
        split_hold[win_master] <= 1'b0;
      end else if (do_park) begin
        split_valid            <= split_valid | sel_mask;
        split_owner            <= sel_master ? (split_owner | sel_mask) : (split_owner & ~sel_mask);
        split_hold[sel_master] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      arb_busy   <= 1'b0;
      m1_grant   <= 1'b0;
      m2_grant   <= 1'b0;
      bus_busy   <= 1'b0;
      sel_master <= 1'b0;
      sel_slave  <= '0;
      sel_err    <= 1'b0;
      win_master <= 1'b0;
      win_resume <= 1'b0;
      win_slave  <= '0;
    end else begin
      sel_err  <= 1'b0;
      arb_busy <= 1'b0;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          state <= ST_IDLE;
          if (pick_valid) begin
            state      <= ST_ARB;
            arb_busy   <= 1'b1;
            win_master <= pick_master;
            win_resume <= pick_resume;
            win_slave  <= pick_slave;
          end
        end
        ST_ARB: begin
          if (win_bad) begin
            sel_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            state      <= ST_GRANT;
            sel_master <= win_master;
            sel_slave  <= win_slave;
            m1_grant   <= !win_master;
            m2_grant   <= win_master;
            bus_busy   <= 1'b1;
          end
        end
        default: begin
          if (tx_done || do_park || to_fire) begin
            state    <= ST_RELEASE;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] grant_cnt;

  assign to_fire = (state == ST_GRANT) && !tx_done && !do_park
                   && (grant_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;
      if (state != ST_GRANT) begin
        grant_cnt <= '0;
      end else if (grant_cnt != CNT_W'(TIMEOUT)) begin
        grant_cnt <= grant_cnt + 1'b1;
      end
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
